// File: rtl/fme_pkg.sv
// Shared definitions for the fractional motion estimation SAD path:
// lane count, FSM state encoding and output width helpers.
package fme_pkg;

  localparam int LANES = 16;

  typedef logic [1:0] fme_state_t;
  localparam fme_state_t IDLE  = 2'd0;
  localparam fme_state_t RUN   = 2'd1;
  localparam fme_state_t DRAIN = 2'd2;

  // Sixteen lanes of |diff| < 2^dw each sum to less than 2^(dw+4).
  function automatic int row_sad_width(input int dw);
    return dw + 4;
  endfunction

  function automatic int sad_width(input int dw, input int rows);
    return dw + 4 + $clog2(rows);
  endfunction

  function automatic int idx_width(input int ncand);
    return $clog2(ncand);
  endfunction

endpackage

// File: rtl/fme_row_sad.sv
// One row of SAD: 16 lane absolute differences summed by a balanced adder
// tree, registered together with the row's candidate index and last-row flag.
module fme_row_sad
  import fme_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 3,
  localparam int ROW_W     = row_sad_width(DATA_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid_i,
  input  logic                        in_last_i,
  input  logic [IDX_W-1:0]            in_idx_i,
  input  logic [LANES*DATA_WIDTH-1:0] ref_row_i,
  input  logic [LANES*DATA_WIDTH-1:0] org_row_i,
  output logic                        row_valid_o,
  output logic                        row_last_o,
  output logic [IDX_W-1:0]            row_idx_o,
  output logic [ROW_W-1:0]            row_sad_o
);

  logic [DATA_WIDTH:0] lane_abs [LANES];
  logic [ROW_W-1:0]    lvl [LANES];
  logic [ROW_W-1:0]    row_sum;

  logic                valid_q;
  logic                last_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ROW_W-1:0]    sad_q;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_WIDTH:0] diff;
      assign diff = {1'b0, ref_row_i[gi*DATA_WIDTH +: DATA_WIDTH]}
                  - {1'b0, org_row_i[gi*DATA_WIDTH +: DATA_WIDTH]};
      // The sign bit of the widened difference selects the two's complement.
      assign lane_abs[gi] = diff[DATA_WIDTH] ? (~diff + 1'b1) : diff;
    end
  endgenerate

  // Pairwise reduction in place: each pass halves the number of live terms.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lvl[i] = {{(ROW_W-DATA_WIDTH-1){1'b0}}, lane_abs[i]};
    end
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        lvl[i] = lvl[2*i] + lvl[2*i+1];
      end
    end
    row_sum = lvl[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      sad_q   <= '0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        last_q <= in_last_i;
        idx_q  <= in_idx_i;
        sad_q  <= row_sum;
      end
    end
  end

  assign row_valid_o = valid_q;
  assign row_last_o  = last_q;
  assign row_idx_o   = idx_q;
  assign row_sad_o   = sad_q;

endmodule

// File: rtl/fme_sad_accum.sv
// Per-candidate SAD accumulation and minimum-SAD candidate selection.
// Define FME_SAD_CAND_OUT_EN to expose each candidate's final SAD as it closes.
module fme_sad_accum
  import fme_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROWS   = 16,
  parameter int NUM_CAND   = 8,
  localparam int SAD_W     = sad_width(DATA_WIDTH, NUM_ROWS),
  localparam int IDX_W     = idx_width(NUM_CAND)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        row_valid,
  output logic                        row_ready,
  input  logic [LANES*DATA_WIDTH-1:0] ref_row,
  input  logic [LANES*DATA_WIDTH-1:0] org_row,
  output logic                        busy,
  output logic                        done,
  output logic [SAD_W-1:0]            best_sad,
  output logic [IDX_W-1:0]            best_idx
`ifdef FME_SAD_CAND_OUT_EN
  ,
  output logic                        cand_sad_valid,
  output logic [SAD_W-1:0]            cand_sad,
  output logic [IDX_W-1:0]            cand_idx
`endif
);

  localparam int RCNT_W = $clog2(NUM_ROWS);
  localparam int ROW_W  = row_sad_width(DATA_WIDTH);
  localparam logic [RCNT_W-1:0] ROW_LAST  = RCNT_W'(NUM_ROWS - 1);
  localparam logic [IDX_W-1:0]  CAND_LAST = IDX_W'(NUM_CAND - 1);

  fme_state_t        state_q, state_d;
  logic [RCNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [IDX_W-1:0]  cand_cnt_q, cand_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SAD_W-1:0]  acc_q, acc_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;

  logic              hs;
  logic              start_ok;
  logic              pipe_valid;
  logic              pipe_last;
  logic [IDX_W-1:0]  pipe_idx;
  logic [ROW_W-1:0]  pipe_sad;
  logic [SAD_W-1:0]  final_sad;
  logic              close_cand;

  assign row_ready  = (state_q == RUN);
  assign hs         = row_valid && row_ready;
  assign start_ok   = (state_q == IDLE) && start;
  assign final_sad  = acc_q + {{(SAD_W-ROW_W){1'b0}}, pipe_sad};
  assign close_cand = pipe_valid && pipe_last;

  fme_row_sad #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_row_sad (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (hs),
    .in_last_i   (row_cnt_q == ROW_LAST),
    .in_idx_i    (cand_cnt_q),
    .ref_row_i   (ref_row),
    .org_row_i   (org_row),
    .row_valid_o (pipe_valid),
    .row_last_o  (pipe_last),
    .row_idx_o   (pipe_idx),
    .row_sad_o   (pipe_sad)
  );

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    cand_cnt_d = cand_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          row_cnt_d  = '0;
          cand_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        if (hs) begin
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d  = '0;
            cand_cnt_d = cand_cnt_q + 1'b1;
            if (cand_cnt_q == CAND_LAST) begin
              state_d = DRAIN;
            end
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // The final row closes its candidate one edge after entry here.
        if (!pipe_valid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    if (start_ok) begin
      acc_d = '0;
    end else if (pipe_valid) begin
      if (pipe_last) begin
        acc_d = '0;
        // Strict less-than keeps the lowest index on ties.
        if ((pipe_idx == '0) || (final_sad < best_sad_q)) begin
          best_sad_d = final_sad;
          best_idx_d = pipe_idx;
        end
      end else begin
        acc_d = final_sad;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      cand_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      cand_cnt_q <= cand_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

`ifdef FME_SAD_CAND_OUT_EN
  logic             cand_valid_q, cand_valid_d;
  logic [SAD_W-1:0] cand_sad_q, cand_sad_d;
  logic [IDX_W-1:0] cand_idx_q, cand_idx_d;

  always_comb begin
    cand_valid_d = close_cand;
    cand_sad_d   = cand_sad_q;
    cand_idx_d   = cand_idx_q;
    if (close_cand) begin
      cand_sad_d = final_sad;
      cand_idx_d = pipe_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_valid_q <= 1'b0;
      cand_sad_q   <= '0;
      cand_idx_q   <= '0;
    end else begin
      cand_valid_q <= cand_valid_d;
      cand_sad_q   <= cand_sad_d;
      cand_idx_q   <= cand_idx_d;
    end
  end

  assign cand_sad_valid = cand_valid_q;
  assign cand_sad       = cand_sad_q;
  assign cand_idx       = cand_idx_q;
`else
  logic unused_close;
  assign unused_close = close_cand;
`endif

endmodule

// File: tb/tb_fme_sad_accum.sv
// Directed bench for fme_sad_accum: a per-candidate SAD model built from
// plain arithmetic drives a per-cycle compare process plus literal checks.
module tb_fme_sad_accum;

  localparam int DW    = 8;
  localparam int NR    = 16;
  localparam int NC    = 8;
  localparam int TOTAL = NR * NC;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           row_valid;
  logic           row_ready;
  logic [16*DW-1:0] ref_row;
  logic [16*DW-1:0] org_row;
  logic           busy;
  logic           done;
  logic [15:0]    best_sad;
  logic [2:0]     best_idx;
`ifdef FME_SAD_CAND_OUT_EN
  logic           cand_sad_valid;
  logic [15:0]    cand_sad;
  logic [2:0]     cand_idx;
`endif

  int tests = 0;
  int fails = 0;

  int seq = 0;
  int last_seq = 0;
  bit mon_en = 1'b0;
  int hs_n = 0;
  int cd = 0;
  int cand_seen = 0;
  int done_cnt = 0;
  int exp_sad = 0;
  int exp_idx = 0;
  int cand_exp [NC];

  fme_sad_accum dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .ref_row   (ref_row),
    .org_row   (org_row),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .best_idx  (best_idx)
`ifdef FME_SAD_CAND_OUT_EN
    ,
    .cand_sad_valid (cand_sad_valid),
    .cand_sad       (cand_sad),
    .cand_idx       (cand_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int ref_v(input int pat, input int k, input int r, input int l);
    int d;
    case (pat)
      0: return 100 + absdiff(k, 5);
      1: return 102;
      2: return 255;
      3: return (k * 37 + r * 11 + l * 5) % 256;
      4: begin
        d = (k == 6) ? 1 : (2 + k);
        return (l % 2 == 1) ? 100 - d : 100 + d;
      end
      default: return 0;
    endcase
  endfunction

  function automatic int org_v(input int pat, input int r, input int l);
    case (pat)
      2: return 0;
      3: return (l * 29 + r * 7 + 13) % 256;
      default: return 100;
    endcase
  endfunction

  function automatic int cand_model(input int pat, input int k);
    int s = 0;
    for (int r = 0; r < NR; r++)
      for (int l = 0; l < 16; l++)
        s += absdiff(ref_v(pat, k, r, l), org_v(pat, r, l));
    return s;
  endfunction

  // Compare process: done timing, drain backpressure and results every cycle.
  always @(negedge clk) begin
    bit exp_d;
    if (mon_en && !rst) begin
      if (seq != last_seq) begin
        last_seq  = seq;
        hs_n      = 0;
        cd        = 0;
        cand_seen = 0;
      end
      exp_d = (cd == 1);
      if (cd > 0) cd--;
      chk("done_timing", int'(done), int'(exp_d));
      if (cd > 0) chk("ready_in_drain", int'(row_ready), 0);
`ifdef FME_SAD_CAND_OUT_EN
      if (cand_sad_valid) begin
        chk("cand_idx", int'(cand_idx), cand_seen);
        if (cand_seen < NC) chk("cand_sad", int'(cand_sad), cand_exp[cand_seen]);
        cand_seen++;
      end
`endif
      if (done) begin
        done_cnt++;
        chk("best_sad", int'(best_sad), exp_sad);
        chk("best_idx", int'(best_idx), exp_idx);
`ifdef FME_SAD_CAND_OUT_EN
        chk("cand_count", cand_seen, NC);
`endif
      end
      if (row_valid && row_ready) begin
        hs_n++;
        if (hs_n == TOTAL) cd = 3;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_row_ready"}, int'(row_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_best_sad"}, int'(best_sad), 0);
    chk({tag, "_best_idx"}, int'(best_idx), 0);
`ifdef FME_SAD_CAND_OUT_EN
    chk({tag, "_cand_valid"}, int'(cand_sad_valid), 0);
    chk({tag, "_cand_sad"}, int'(cand_sad), 0);
`endif
  endtask

  task automatic run_search(input int pat, input bit gaps, input bit pokes,
                            input int abort_at, input bit pre, input bit chain,
                            input int lit_sad, input int lit_idx);
    int  di = 0;
    int  guard = 0;
    int  d0;
    int  bs = 0;
    int  bi = 0;
    int  cs;
    bit  acc;
    bit  got = 1'b0;
    logic [7:0] tmp;
    for (int k = 0; k < NC; k++) begin
      cs = cand_model(pat, k);
      cand_exp[k] = cs;
      if (k == 0 || cs < bs) begin
        bs = cs;
        bi = k;
      end
    end
    exp_sad = bs;
    exp_idx = bi;
    d0 = done_cnt;
    if (!pre) begin
      @(posedge clk); #1;
      start = 1'b1;
      seq++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("busy_on_start", int'(busy), 1);
    while (di < TOTAL && guard < 3000) begin
      row_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = pokes && (guard % 7 == 2);
      for (int l = 0; l < 16; l++) begin
        tmp = 8'(ref_v(pat, di / NR, di % NR, l));
        ref_row[l*DW +: DW] = tmp;
        tmp = 8'(org_v(pat, di % NR, l));
        org_row[l*DW +: DW] = tmp;
      end
      @(negedge clk);
      acc = row_valid && row_ready;
      @(posedge clk); #1;
      if (acc) di++;
      guard++;
      if (abort_at > 0 && di == abort_at) begin
        row_valid = 1'b0;
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("abort_rst");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("ready_after_rst", int'(row_ready), 0);
          chk("busy_after_rst", int'(busy), 0);
        end
        return;
      end
    end
    row_valid = 1'b0;
    start = 1'b0;
    chk("rows_accepted", di, TOTAL);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) got = 1'b1;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("busy_after_done", int'(busy), 0);
    if (lit_sad >= 0) begin
      chk("lit_best_sad", int'(best_sad), lit_sad);
      chk("lit_best_idx", int'(best_idx), lit_idx);
    end
    if (chain) begin
      #1;
      start = 1'b1;
      seq++;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    row_valid = 1'b0;
    ref_row = '0;
    org_row = '0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_idle", int'(row_ready), 0);
    mon_en = 1'b1;

    // unique minimum at candidate 5
    run_search(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 5);
    // all candidates tie; start pulsed in the done cycle chains the next search
    run_search(1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 512, 0);
    // full-scale differences, no wrap
    run_search(2, 1'b0, 1'b0, 0, 1'b1, 1'b0, 65280, 0);
    // gaps on row_valid plus stray start pulses during RUN
    run_search(0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 5);
    // differences of both signs, minimum at candidate 6
    run_search(4, 1'b0, 1'b0, 0, 1'b0, 1'b0, 256, 6);
    // mixed per-lane data, model only
    run_search(3, 1'b1, 1'b0, 0, 1'b0, 1'b0, -1, 0);
    // reset after 40 rows, then a clean search
    run_search(0, 1'b0, 1'b0, 40, 1'b0, 1'b0, -1, 0);
    run_search(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 5);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
